// File: rtl/vga_frame_update_scheduler_if.sv
// Sample producer / VGA colour bus for vga_frame_update_scheduler.
// slave = scheduler side, master = producer/VGA side.
interface vga_frame_update_scheduler_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          sample_valid;
    logic [11:0]   sample_data;
    logic          sample_ready;
    logic          vsync;
    logic          validData;
    logic [11:0]   data;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic [7:0]    drop_cnt;

    modport slave (
        input  sample_valid, sample_data, vsync,
        output sample_ready, validData, data, fifo_level, overflow, drop_cnt
    );

    modport master (
        output sample_valid, sample_data, vsync,
        input  sample_ready, validData, data, fifo_level, overflow, drop_cnt
    );
endinterface

// File: rtl/vga_frame_update_scheduler.sv
// Buffers RGB444 samples and releases one per frame at the vsync falling edge.
// Optional HOLD_TIMEOUT_EN: force black after TIMEOUT_FRAMES idle frames.
module vga_frame_update_scheduler #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_FRAMES = 60
) (
    input  logic                          clk,
    input  logic                          rst,
    vga_frame_update_scheduler_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {IDLE, ARMED, ISSUE} state_e;

    state_e         state_q, state_d;
    logic [11:0]    mem_q [DEPTH];
    logic [11:0]    mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           vsync_q;
    logic           valid_q, valid_d;
    logic [11:0]    data_q, data_d;
    logic           overflow_q, overflow_d;
    logic [7:0]     drop_q, drop_d;

    logic frame_tick_c, ready_c, push_c, refuse_c, pop_c, timeout_c;

    assign frame_tick_c = vsync_q & ~bus.vsync;
    // Readiness uses the pre-pop level: a full FIFO refuses even on a pop cycle.
    assign ready_c      = (level_q != LW'(DEPTH));
    assign push_c       = bus.sample_valid & ready_c;
    assign refuse_c     = bus.sample_valid & ~ready_c;
    assign pop_c        = frame_tick_c & (level_q != '0);

`ifdef HOLD_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_FRAMES + 1);

    logic [CW-1:0] frame_cnt_q, frame_cnt_d;

    // Count empty-FIFO frame ticks; fire a black strobe on the last one.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        timeout_c   = 1'b0;
        if (push_c || pop_c) begin
            frame_cnt_d = '0;
        end else if (frame_tick_c) begin
            if (frame_cnt_q == CW'(TIMEOUT_FRAMES - 1)) begin
                timeout_c   = 1'b1;
                frame_cnt_d = '0;
            end else begin
                frame_cnt_d = frame_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) frame_cnt_q <= '0;
        else      frame_cnt_q <= frame_cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_FRAMES == 0);
    assign timeout_c      = 1'b0;
`endif

    // FIFO bookkeeping, strobe generation and FSM.
    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q + LW'(push_c) - LW'(pop_c);
        valid_d    = 1'b0;
        data_d     = data_q;
        overflow_d = overflow_q | refuse_c;
        drop_d     = drop_q;

        if (refuse_c && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

        if (push_c) begin
            mem_d[wr_ptr_q] = bus.sample_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end

        if (pop_c) begin
            valid_d  = 1'b1;
            data_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else if (timeout_c) begin
            valid_d = 1'b1;
            data_d  = 12'h000;
        end

        case (state_q)
            IDLE:    if (push_c) state_d = ARMED;
            ARMED:   if (pop_c)  state_d = ISSUE;
            ISSUE:   state_d = (level_q != '0 || push_c) ? ARMED : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 12'h000;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            vsync_q    <= 1'b1;
            valid_q    <= 1'b0;
            data_q     <= 12'h000;
            overflow_q <= 1'b0;
            drop_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            vsync_q    <= bus.vsync;
            valid_q    <= valid_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.sample_ready = ready_c;
    assign bus.validData    = valid_q;
    assign bus.data         = data_q;
    assign bus.fifo_level   = level_q;
    assign bus.overflow     = overflow_q;
    assign bus.drop_cnt     = drop_q;
endmodule
